// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_pkg                                                   |
// | Purpose  : Shared constants and state type for the memory responder. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam int          MEM_DATA_W = 32;
  localparam logic [31:0] RV32I_NOP  = 32'h00000013;

  // Sequencer state: sweeping the array with the fill word, or serving accesses
  typedef enum logic {
    MEM_FILL  = 1'b0,
    MEM_READY = 1'b1
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_fill_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_fill_sequencer                                        |
// | Purpose  : Post-reset fill FSM. Walks word 0..DEPTH-1 one per cycle, |
// |            then parks in READY until the next reset.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_fill_sequencer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_idx,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_last;

  assign w_last = (r_cnt == c_last_idx);

  // State register; reset aborts any fill in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MEM_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave FILL on the cycle that writes the last word
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MEM_FILL:  if (w_last) w_state_nxt = MEM_READY;
      MEM_READY: w_state_nxt = MEM_READY;
      default:   w_state_nxt = MEM_FILL;
    endcase
  end

  // Fill counter; freezes on the last index so it never runs past the array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == MEM_FILL && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs decoded from the current state only
  always_comb begin
    fill_we  = (r_state == MEM_FILL);
    fill_idx = r_cnt;
    ready    = (r_state == MEM_READY);
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_responder                                             |
// | Purpose  : Word-addressed single-port RAM serving processor fetch    |
// |            and store traffic; filled with FILL_VALUE after reset.    |
// | Options  : MEM_ERR_EN adds a sticky out-of-range flag and captures   |
// |            the first offending address.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_responder
  import mem_pkg::*;
#(
  parameter int                    DEPTH      = 1024,
  parameter logic [MEM_DATA_W-1:0] FILL_VALUE = RV32I_NOP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_wr_en,
  input  logic [MEM_DATA_W-1:0] mem_wr_data,
  output logic [MEM_DATA_W-1:0] mem_rd_data,
  output logic                  mem_rd_valid,
  output logic                  mem_ready
`ifdef MEM_ERR_EN
  ,
  output logic                  mem_err,
  output logic [31:0]           mem_err_addr
`endif
);

  localparam int          ADDR_W  = $clog2(DEPTH);
  localparam logic [31:0] c_depth = 32'(DEPTH);

  logic [MEM_DATA_W-1:0] r_mem [DEPTH];

  logic                  w_fill_we;
  logic [ADDR_W-1:0]     w_fill_idx;
  logic                  w_in_range;
  logic [ADDR_W-1:0]     w_idx;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_waddr;
  logic [MEM_DATA_W-1:0] w_wdata;
  logic [MEM_DATA_W-1:0] r_rd_data;
  logic                  r_rd_valid;

  mem_fill_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fill_seq (
    .clk      (clk),
    .rst      (rst),
    .fill_we  (w_fill_we),
    .fill_idx (w_fill_idx),
    .ready    (mem_ready)
  );

  // Full 32-bit unsigned compare, so high address bits can never alias low words
  assign w_in_range = (mem_addr < c_depth);
  assign w_idx      = mem_addr[ADDR_W-1:0];

  // Single write port: sequencer owns it during fill, processor afterwards
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_fill_idx;
    w_wdata = FILL_VALUE;
    if (mem_ready) begin
      w_we    = mem_wr_en && w_in_range;
      w_waddr = w_idx;
      w_wdata = mem_wr_data;
    end else begin
      w_we    = w_fill_we;
    end
  end

  // Array write; the storage itself is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read: one-cycle latency, out-of-range reads return zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (mem_ready) begin
      if (mem_wr_en) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_in_range ? r_mem[w_idx] : '0;
      end
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign mem_rd_data  = r_rd_data;
  assign mem_rd_valid = r_rd_valid;

`ifdef MEM_ERR_EN
  logic        r_err;
  logic [31:0] r_err_addr;

  // Sticky error: only the first out-of-range accepted access is recorded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (mem_ready && !w_in_range && !r_err) begin
      r_err      <= 1'b1;
      r_err_addr <= mem_addr;
    end
  end

  assign mem_err      = r_err;
  assign mem_err_addr = r_err_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mem_responder                                          |
// | Purpose  : Scoreboard bench for mem_responder with DEPTH=16. Reads   |
// |            push expected data and response cycle; a negedge monitor  |
// |            pops and compares whenever mem_rd_valid is high.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_wr_en = 1'b0;
  logic [31:0] mem_wr_data = '0;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_ready;
`ifdef MEM_ERR_EN
  logic        mem_err;
  logic [31:0] mem_err_addr;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t m_e;

  mem_responder #(
    .DEPTH      (DEPTH),
    .FILL_VALUE (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_ready    (mem_ready)
`ifdef MEM_ERR_EN
    ,
    .mem_err      (mem_err),
    .mem_err_addr (mem_err_addr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid response must match the oldest outstanding read
  always @(negedge clk) begin
    if (mem_rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd: got %h expected no response", mem_rd_data);
      end else begin
        m_e = sb.pop_front();
        check("rd_data", mem_rd_data, m_e.data);
        check("rd_cycle", 32'(cyc), 32'(m_e.cyc));
      end
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    @(posedge clk);
    #1;
    mem_wr_en = 1'b0;
    mem_addr  = a;
    sb.push_back('{exp, cyc + 1});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    mem_wr_en   = 1'b1;
    mem_addr    = a;
    mem_wr_data = d;
  endtask

  // After a write is accepted: no response, read data held
  task automatic chk_hold(input logic [31:0] exp);
    @(posedge clk);
    @(negedge clk);
    check("wr_valid", {31'b0, mem_rd_valid}, 32'd0);
    check("wr_hold", mem_rd_data, exp);
  endtask

  // Called just after rst release: ready low for DEPTH cycles, then high.
  // The final fill cycle sets up a read of a_last that is accepted in the first ready cycle.
  task automatic fill_wait(input logic [31:0] a_last, input logic [31:0] exp_last);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      check("fill_ready", {31'b0, mem_ready}, 32'd0);
      check("fill_valid", {31'b0, mem_rd_valid}, 32'd0);
      if (k == DEPTH - 1) begin
        mem_wr_en = 1'b0;
        mem_addr  = a_last;
        sb.push_back('{exp_last, cyc + 2});
      end
    end
    @(negedge clk);
    check("ready_rise", {31'b0, mem_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Processor tries to store during fill; must be ignored
    rst         = 1'b1;
    mem_wr_en   = 1'b1;
    mem_addr    = 32'd3;
    mem_wr_data = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_data", mem_rd_data, 32'd0);
    check("rst_valid", {31'b0, mem_rd_valid}, 32'd0);
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
`ifdef MEM_ERR_EN
    check("rst_err", {31'b0, mem_err}, 32'd0);
    check("rst_err_addr", mem_err_addr, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    check("fill_rd_data", mem_rd_data, 32'd0);
    fill_wait(32'd3, NOP);
`ifdef MEM_ERR_EN
    check("err_clear", {31'b0, mem_err}, 32'd0);
`endif

    // Streaming fetch of every word, one per cycle
    for (int i = 0; i < DEPTH; i++) rd(32'(i), NOP);

    // Write then read back
    wr(32'd5, 32'hDEADBEEF);
    chk_hold(NOP);
    rd(32'd5, 32'hDEADBEEF);
    rd(32'd6, NOP);
    wr(32'd2, 32'hCAFEF00D);
    chk_hold(NOP);
    rd(32'd2, 32'hCAFEF00D);

    // Out-of-range accesses: dropped writes, zero reads, no aliasing
    wr(32'd16, 32'h12345678);
    chk_hold(32'hCAFEF00D);
`ifdef MEM_ERR_EN
    check("err_set", {31'b0, mem_err}, 32'd1);
    check("err_addr", mem_err_addr, 32'd16);
`endif
    wr(32'h80000000, 32'h12345678);
    chk_hold(32'hCAFEF00D);
`ifdef MEM_ERR_EN
    check("err_addr_keep", mem_err_addr, 32'd16);
`endif
    rd(32'd0, NOP);
    rd(32'd16, 32'd0);
    rd(32'h80000000, 32'd0);
    rd(32'd15, NOP);
    @(posedge clk);
    @(negedge clk);
`ifdef MEM_ERR_EN
    check("err_addr_keep2", mem_err_addr, 32'd16);
`endif

    // Reset from READY drops ready immediately
    #2;
    mem_wr_en = 1'b0;
    mem_addr  = 32'd0;
    rst       = 1'b1;
    #1;
    check("rst_ready_drop", {31'b0, mem_ready}, 32'd0);
    check("rst_valid_drop", {31'b0, mem_rd_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-fill at fill cycle 7, held for 2 cycles
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midfill_ready", {31'b0, mem_ready}, 32'd0);
`ifdef MEM_ERR_EN
    check("midfill_err", {31'b0, mem_err}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fill_wait(32'd5, NOP);
    rd(32'd2, NOP);
    rd(32'd15, NOP);

    // Let the last response be seen, then quiesce with reset
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
